// File: rtl/stopwatch_time_counter.sv
// stopwatch_time_counter: synchronises a gated ms tick and accumulates MM:SS.mmm in BCD with sticky overflow.
// Optional lap-hold display snapshot is compiled in with STOPWATCH_LAP_HOLD_EN.
module stopwatch_time_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_MAX = 59
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ms_tick_in,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] ms_ones,
  output logic [3:0] ms_tens,
  output logic [3:0] ms_hund,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       count_pulse,
  output logic       overflow
);
  logic [SYNC_STAGES-1:0] sync;
  logic hist, armed, rise, wrap;
  logic [2:0] arm_cnt;
  logic [3:0] q_mo, q_mt, q_mh, q_so, q_mi, q_mn;
  logic [2:0] q_st;
  logic [3:0] n_mo, n_mt, n_mh, n_so, n_mi, n_mn;
  logic [2:0] n_st;
  logic c_mt, c_mh, c_so, c_st, c_mi, c_mn;
  logic [7:0] mins;
  logic [26:0] live;
  function automatic logic [3:0] bump(input logic [3:0] d, input logic [3:0] lim, input logic ci);
    return !ci ? d : (d >= lim ? 4'd0 : d + 4'd1);
  endfunction
  assign rise = sync[SYNC_STAGES-1] & ~hist & armed;
  // Out-of-range digits compare as >= limit, so they carry instead of sticking.
  always_comb begin
    c_mt = q_mo >= 4'd9;
    c_mh = c_mt & (q_mt >= 4'd9);
    c_so = c_mh & (q_mh >= 4'd9);
    c_st = c_so & (q_so >= 4'd9);
    c_mi = c_st & (q_st >= 3'd5);
    c_mn = c_mi & (q_mi >= 4'd9);
    mins = 8'(q_mn) * 8'd10 + 8'(q_mi);
    wrap = c_mi & (mins >= 8'(MIN_MAX));
    n_mo = bump(q_mo, 4'd9, 1'b1);
    n_mt = bump(q_mt, 4'd9, c_mt);
    n_mh = bump(q_mh, 4'd9, c_mh);
    n_so = bump(q_so, 4'd9, c_so);
    n_st = 3'(bump({1'b0, q_st}, 4'd5, c_st));
    n_mi = wrap ? 4'd0 : bump(q_mi, 4'd9, c_mi);
    n_mn = wrap ? 4'd0 : bump(q_mn, 4'd9, c_mn);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      hist <= 1'b0;
      armed <= 1'b0;
      arm_cnt <= 3'd0;
      count_pulse <= 1'b0;
      overflow <= 1'b0;
      {q_mn, q_mi, q_st, q_so, q_mh, q_mt, q_mo} <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ms_tick_in};
      hist <= sync[SYNC_STAGES-1];
      if (!armed) arm_cnt <= arm_cnt + 3'd1;
      armed <= armed | (arm_cnt == 3'(SYNC_STAGES));
      count_pulse <= rise & ~clear;
      if (clear) begin
        {q_mn, q_mi, q_st, q_so, q_mh, q_mt, q_mo} <= '0;
        overflow <= 1'b0;
      end else if (rise) begin
        {q_mn, q_mi, q_st, q_so, q_mh, q_mt, q_mo} <= {n_mn, n_mi, n_st, n_so, n_mh, n_mt, n_mo};
        overflow <= overflow | wrap;
      end
    end
  end
  assign live = {q_mn, q_mi, q_st, q_so, q_mh, q_mt, q_mo};
`ifdef STOPWATCH_LAP_HOLD_EN
  logic lap_q, hold;
  logic [26:0] snap;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lap_q <= 1'b0;
      hold <= 1'b0;
      snap <= '0;
    end else begin
      lap_q <= lap;
      if (clear) begin
        hold <= 1'b0;
        snap <= '0;
      end else if (lap & ~lap_q) begin
        hold <= ~hold;
        if (!hold) snap <= live;
      end
    end
  end
  assign {min_tens, min_ones, sec_tens, sec_ones, ms_hund, ms_tens, ms_ones} = hold ? snap : live;
`else
  logic lap_unused;
  assign lap_unused = lap;
  assign {min_tens, min_ones, sec_tens, sec_ones, ms_hund, ms_tens, ms_ones} = live;
`endif
endmodule

// File: tb/tb_stopwatch_time_counter.sv
// tb_stopwatch_time_counter: scoreboarded random-tick bench with a millisecond-integer reference model.
module tb_stopwatch_time_counter;
  localparam int MINMAX = 1;
  localparam int MAXMS = (MINMAX * 60 + 59) * 1000 + 999;
  logic clock = 0, reset_n = 0, ms_tick_in = 0, clear = 0, lap = 0;
  logic [3:0] ms_ones, ms_tens, ms_hund, sec_ones, min_ones, min_tens;
  logic [2:0] sec_tens;
  logic count_pulse, overflow;
  logic [27:0] act, snap_m = '0;
  logic [27:0] expq[$];
  int total = 0, bad = 0, pulse_cnt = 0, p0 = 0, ms_m = 0;
  bit ovf_m = 0, hold_m = 0;
  logic [3:0] p_mo, p_mt, p_mh, p_so, p_mi, p_mn;
  logic [2:0] p_st;
  stopwatch_time_counter #(.SYNC_STAGES(2), .MIN_MAX(MINMAX)) dut (
    .clock(clock), .reset_n(reset_n), .ms_tick_in(ms_tick_in), .clear(clear), .lap(lap),
    .ms_ones(ms_ones), .ms_tens(ms_tens), .ms_hund(ms_hund), .sec_ones(sec_ones),
    .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .count_pulse(count_pulse), .overflow(overflow)
  );
  always #5 clock = ~clock;
  assign act = {min_tens, min_ones, sec_tens, sec_ones, ms_hund, ms_tens, ms_ones, overflow};
  function automatic logic [27:0] pack(int ms, bit ov);
    int mn;
    mn = ms / 60000;
    return {4'(mn / 10), 4'(mn % 10), 3'((ms / 10000) % 6), 4'((ms / 1000) % 10),
            4'((ms / 100) % 10), 4'((ms / 10) % 10), 4'(ms % 10), ov};
  endfunction
  task automatic chk(string nm, logic [27:0] a, logic [27:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask
  task automatic bump_model();
    if (ms_m >= MAXMS) begin
      ms_m = 0;
      ovf_m = 1;
    end else ms_m++;
    expq.push_back(pack(ms_m, ovf_m));
  endtask
  task automatic tick(int hi, int lo);
    @(posedge clock);
    #1 ms_tick_in = 1;
    bump_model();
    repeat (hi) @(posedge clock);
    #1 ms_tick_in = 0;
    repeat (lo) @(posedge clock);
  endtask
  task automatic do_clear(int n);
    @(posedge clock);
    #1 clear = 1;
    repeat (n) @(posedge clock);
    #1 clear = 0;
    ms_m = 0;
    ovf_m = 0;
    hold_m = 0;
    @(negedge clock);
    chk("clear", act, pack(0, 0));
  endtask
  task preload(int ms);
    p_mo = 4'(ms % 10);
    p_mt = 4'((ms / 10) % 10);
    p_mh = 4'((ms / 100) % 10);
    p_so = 4'((ms / 1000) % 10);
    p_st = 3'((ms / 10000) % 6);
    p_mi = 4'((ms / 60000) % 10);
    p_mn = 4'(ms / 600000);
    @(negedge clock);
    force dut.q_mo = p_mo;
    force dut.q_mt = p_mt;
    force dut.q_mh = p_mh;
    force dut.q_so = p_so;
    force dut.q_st = p_st;
    force dut.q_mi = p_mi;
    force dut.q_mn = p_mn;
    @(negedge clock);
    release dut.q_mo;
    release dut.q_mt;
    release dut.q_mh;
    release dut.q_so;
    release dut.q_st;
    release dut.q_mi;
    release dut.q_mn;
    ms_m = ms;
    @(negedge clock);
    chk("preload", act, pack(ms, ovf_m));
  endtask
  // Monitor: every strobe consumes one expected live value; during hold the digits come from the snapshot.
  always @(negedge clock) begin
    logic [27:0] e;
    if (reset_n && count_pulse) begin
      pulse_cnt++;
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got %h want no strobe", act);
      end else begin
        e = expq.pop_front();
        if (hold_m) e = {snap_m[27:1], e[0]};
        chk("count", act, e);
      end
    end
  end
  initial begin
    ms_tick_in = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_digits", act, pack(0, 0));
    chk("reset_pulse", 28'(count_pulse), 28'd0);
    @(posedge clock);
    #1 reset_n = 1;
    p0 = pulse_cnt;
    repeat (6) @(posedge clock);
    #1 ms_tick_in = 0;
    repeat (3) @(posedge clock);
    repeat (3) tick(2, 2);
    repeat (6) @(posedge clock);
    @(negedge clock);
    chk("arm_pulses", 28'(pulse_cnt - p0), 28'd3);
    chk("arm_count", act, pack(3, 0));
    @(posedge clock);
    #1 ms_tick_in = 1;
    bump_model();
    for (int k = 0; k <= 4; k++) begin
      @(negedge clock);
      chk($sformatf("latency_%0d", k), 28'(count_pulse), 28'(k == 3));
    end
    ms_tick_in = 0;
    repeat (3) @(posedge clock);
    for (int i = 0; i < 150; i++) begin
      tick($urandom_range(2, 5), $urandom_range(2, 5));
      if ($urandom_range(0, 29) == 0) do_clear($urandom_range(1, 3));
    end
    preload(41);
    p0 = pulse_cnt;
    @(posedge clock);
    #1 ms_tick_in = 1;
    @(posedge clock);
    @(posedge clock);
    #1 clear = 1;
    @(posedge clock);
    #1 clear = 0;
    ms_m = 0;
    ovf_m = 0;
    @(negedge clock);
    chk("clear_vs_edge_digits", act, pack(0, 0));
    chk("clear_vs_edge_pulse", 28'(count_pulse), 28'd0);
    repeat (4) @(posedge clock);
    #1 ms_tick_in = 0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("held_tick_not_recounted", 28'(pulse_cnt - p0), 28'd0);
    tick(3, 3);
    preload(59999);
    tick(2, 4);
    @(negedge clock);
    chk("minute_carry", act, pack(60000, 0));
    preload(MAXMS);
    tick(2, 4);
    @(negedge clock);
    chk("wrap", act, pack(0, 1));
    repeat (2) tick(3, 2);
    @(negedge clock);
    chk("overflow_sticky", 28'(overflow), 28'd1);
    do_clear(1);
    preload(2500);
    @(posedge clock);
    #1 lap = 1;
    @(posedge clock);
    #1 lap = 0;
`ifdef STOPWATCH_LAP_HOLD_EN
    hold_m = 1;
    snap_m = pack(2500, 0);
`endif
    repeat (100) tick(2, 2);
    repeat (3) @(posedge clock);
    @(negedge clock);
`ifdef STOPWATCH_LAP_HOLD_EN
    chk("lap_hold_view", act, pack(2500, 0));
`else
    chk("lap_ignored_view", act, pack(2600, 0));
`endif
    @(posedge clock);
    #1 lap = 1;
    @(posedge clock);
    #1 lap = 0;
    hold_m = 0;
    @(negedge clock);
    chk("lap_release", act, pack(2600, 0));
    @(posedge clock);
    #1 lap = 1;
    @(posedge clock);
    #1 lap = 0;
`ifdef STOPWATCH_LAP_HOLD_EN
    hold_m = 1;
    snap_m = pack(2600, 0);
`endif
    do_clear(1);
    tick(2, 4);
    @(negedge clock);
    chk("after_clear_live", act, pack(1, 0));
    for (int k = 0; k < 20 && expq.size() > 0; k++) @(posedge clock);
    chk("drain", 28'(expq.size()), 28'd0);
    @(posedge clock);
    #2 reset_n = 0;
    #1 chk("async_reset", act, pack(0, 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
